line_tracker_fsm: RTL and testbench



---
 rtl/tracker_pkg.sv | 24 ++
 rtl/line_tracker_fsm_debounce.sv | 46 ++++
 rtl/line_tracker_fsm.sv | 177 +++++++++++++++++
 tb/tb_line_tracker_fsm.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Shared types for the line tracker: steering state encoding, search direction
// and the error-width helper.
package tracker_pkg;

  typedef enum logic [2:0] {
    STOP   = 3'd0,
    STRI   = 3'd1,
    RT     = 3'd2,
    LT     = 3'd3,
    SRCH_L = 3'd4,
    SRCH_R = 3'd5
  } state_e;

  typedef enum logic {
    DIR_LT = 1'b0,
    DIR_RT = 1'b1
  } dir_e;

  // Signed width able to hold the sum of all sensor weights.
  function automatic int err_width(input int n_sens);
    return $clog2(n_sens * n_sens) + 1;
  endfunction

endpackage

// File: rtl/line_tracker_fsm_debounce.sv
// Single-bit sensor debounce: the output follows the input only after FILT_LEN
// consecutive differing samples. Used when LINE_TRACKER_FILTER_EN is defined.
module tracker_debounce #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (sample_en) begin
      if (din == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        dout_d = din;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/line_tracker_fsm.sv
// N-sensor line tracker: filtered sensors -> signed position error -> steering
// state/magnitude, with lost-line search, timeout and confirmed stop.
// Define LINE_TRACKER_FILTER_EN to build the per-bit debounce stage.
module line_tracker_fsm
  import tracker_pkg::*;
#(
  parameter int N_SENS       = 5,
  parameter int FILT_LEN     = 4,
  parameter int STOP_CONFIRM = 8,
  parameter int LOST_TIMEOUT = 1000,
  parameter int MAG_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [N_SENS-1:0] sensor,
  output logic [2:0]        state,
  output logic [MAG_W-1:0]  steer_mag,
  output logic              lost,
  output logic              dec_valid
);

  localparam int EW        = err_width(N_SENS);
  localparam int SC_W      = $clog2(STOP_CONFIRM + 1);
  localparam int LC_W      = $clog2(LOST_TIMEOUT + 1);
  localparam int MAG_MAX_I = (1 << MAG_W) - 1;
  localparam logic [SC_W-1:0] STOP_MAX = SC_W'(STOP_CONFIRM);
  localparam logic [LC_W-1:0] LOST_MAX = LC_W'(LOST_TIMEOUT);

  logic [N_SENS-1:0] filt;

`ifdef LINE_TRACKER_FILTER_EN
  for (genvar g = 0; g < N_SENS; g++) begin : g_deb
    tracker_debounce #(.FILT_LEN(FILT_LEN)) u_deb (
      .clk       (clk),
      .reset     (reset),
      .sample_en (sample_en),
      .din       (sensor[g]),
      .dout      (filt[g])
    );
  end
`else
  logic [N_SENS-1:0] filt_q, filt_d;

  always_comb begin
    filt_d = filt_q;
    if (sample_en) filt_d = sensor;
  end

  always_ff @(posedge clk) begin
    if (reset) filt_q <= '0;
    else       filt_q <= filt_d;
  end

  assign filt = filt_q;
`endif

  state_e           state_q, state_d, state_cur;
  dir_e             last_dir_q, last_dir_d;
  logic [MAG_W-1:0] mag_q, mag_d, mag_sat;
  logic             lost_q, lost_d;
  logic             dec_en_q, dec_en_d;
  logic             dec_valid_q, dec_valid_d;
  logic [SC_W-1:0]  stop_cnt_q, stop_cnt_d;
  logic [LC_W-1:0]  lost_cnt_q, lost_cnt_d;
  logic signed [EW-1:0] err_s;
  logic [EW-1:0]        err_abs;
  logic                 all_on, any_on;

  // Weight of sensor i is i - (N_SENS-1)/2, so left-side activity is positive.
  always_comb begin
    err_s = '0;
    for (int i = 0; i < N_SENS; i++) begin
      if (filt[i]) err_s = err_s + EW'(i - (N_SENS - 1) / 2);
    end
    err_abs = err_s[EW-1] ? EW'(-err_s) : EW'(err_s);
    mag_sat = (32'(err_abs) > 32'(MAG_MAX_I)) ? '1 : MAG_W'(err_abs);
    all_on  = &filt;
    any_on  = |filt;
  end

  // Encodings 6 and 7 are treated as STRI.
  always_comb begin
    state_cur = state_q;
    if (state_q > SRCH_R) state_cur = STRI;
  end

  always_comb begin
    state_d     = state_cur;
    last_dir_d  = last_dir_q;
    mag_d       = mag_q;
    lost_d      = lost_q;
    stop_cnt_d  = stop_cnt_q;
    lost_cnt_d  = lost_cnt_q;
    dec_en_d    = sample_en;
    dec_valid_d = dec_en_q;
    if (dec_en_q) begin
      if (all_on) begin
        lost_cnt_d = '0;
        if (stop_cnt_q != STOP_MAX) stop_cnt_d = stop_cnt_q + SC_W'(1);
        if (stop_cnt_d == STOP_MAX) begin
          state_d = STOP;
          mag_d   = '0;
          lost_d  = 1'b0;
        end
      end else if (any_on) begin
        stop_cnt_d = '0;
        lost_cnt_d = '0;
        lost_d     = 1'b0;
        mag_d      = mag_sat;
        if (err_s > 0) begin
          state_d    = RT;
          last_dir_d = DIR_RT;
        end else if (err_s < 0) begin
          state_d    = LT;
          last_dir_d = DIR_LT;
        end else begin
          state_d = STRI;
        end
      end else begin
        stop_cnt_d = '0;
        case (state_cur)
          STOP: begin
            if (!lost_q) begin
              state_d    = (last_dir_q == DIR_RT) ? SRCH_R : SRCH_L;
              lost_d     = 1'b1;
              mag_d      = '1;
              lost_cnt_d = '0;
            end
          end
          SRCH_L, SRCH_R: begin
            if (lost_cnt_q != LOST_MAX) lost_cnt_d = lost_cnt_q + LC_W'(1);
            if (lost_cnt_d == LOST_MAX) begin
              state_d = STOP;
              lost_d  = 1'b1;
              mag_d   = '0;
            end
          end
          default: begin
            state_d    = (last_dir_q == DIR_RT) ? SRCH_R : SRCH_L;
            lost_d     = 1'b1;
            mag_d      = '1;
            lost_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STRI;
      last_dir_q  <= DIR_LT;
      mag_q       <= '0;
      lost_q      <= 1'b0;
      stop_cnt_q  <= '0;
      lost_cnt_q  <= '0;
      dec_en_q    <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      mag_q       <= mag_d;
      lost_q      <= lost_d;
      stop_cnt_q  <= stop_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
      dec_en_q    <= dec_en_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign state     = state_q;
  assign steer_mag = mag_q;
  assign lost      = lost_q;
  assign dec_valid = dec_valid_q;

endmodule

// File: tb/tb_line_tracker_fsm.sv
// Directed bench for line_tracker_fsm with N_SENS=5, FILT_LEN=4, STOP_CONFIRM=8,
// LOST_TIMEOUT=16, MAG_W=4; follows LINE_TRACKER_FILTER_EN for filter depth.
module tb_line_tracker_fsm;

  localparam int N_SENS = 5;
  localparam int FILT   = 4;
  localparam int SC     = 8;
  localparam int LTO    = 16;
  localparam int MAG_W  = 4;
`ifdef LINE_TRACKER_FILTER_EN
  localparam int E = FILT;
`else
  localparam int E = 1;
`endif

  localparam logic [2:0] S_STOP = 3'd0, S_STRI = 3'd1, S_RT = 3'd2, S_LT = 3'd3,
                         S_SRCH_L = 3'd4, S_SRCH_R = 3'd5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sample_en = 1'b0;
  logic [N_SENS-1:0] sensor = '0;
  logic [2:0]        state;
  logic [MAG_W-1:0]  steer_mag;
  logic              lost;
  logic              dec_valid;

  int n_chk = 0;
  int n_err = 0;

  line_tracker_fsm #(
    .N_SENS(N_SENS), .FILT_LEN(FILT), .STOP_CONFIRM(SC),
    .LOST_TIMEOUT(LTO), .MAG_W(MAG_W)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .sensor(sensor),
    .state(state), .steer_mag(steer_mag), .lost(lost), .dec_valid(dec_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One strobe, then wait through the decision edge; returns at a negedge.
  task automatic sample(input logic [N_SENS-1:0] s);
    sensor    = s;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    chk("dec_valid_pulse", 32'(dec_valid), 32'd1);
  endtask

  task automatic run(input logic [N_SENS-1:0] s, input int n);
    for (int k = 0; k < n; k++) sample(s);
  endtask

  task automatic expect_out(input string tag, input logic [2:0] st,
                            input logic [MAG_W-1:0] mag, input logic lst);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_mag"},   32'(steer_mag), 32'(mag));
    chk({tag, "_lost"},  32'(lost), 32'(lst));
  endtask

  initial begin
    // Reset with a coincident strobe that must be discarded.
    sample_en = 1'b1;
    sensor    = 5'b11000;
    repeat (3) @(negedge clk);
    sample_en = 1'b0;
    reset     = 1'b0;
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    expect_out("rst", S_STRI, 4'd0, 1'b0);
    @(negedge clk);
    chk("rst_strobe_dropped", 32'(dec_valid), 32'd0);

    run(5'b00100, 6);
    expect_out("centre", S_STRI, 4'd0, 1'b0);
    @(negedge clk);
    chk("dec_valid_low", 32'(dec_valid), 32'd0);

    // Left pair: exactly E samples plus one clk.
    run(5'b11000, E - 1);
    chk("rt_early", 32'(state), 32'(S_STRI));
    sensor    = 5'b11000;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    chk("rt_one_clk_before", 32'(state), 32'(S_STRI));
    chk("rt_no_valid_yet", 32'(dec_valid), 32'd0);
    @(negedge clk);
    expect_out("rt", S_RT, 4'd3, 1'b0);

`ifdef LINE_TRACKER_FILTER_EN
    for (int k = 0; k < 3; k++) begin
      sample(5'b00011);
      chk("glitch_hold", 32'(state), 32'(S_RT));
    end
    sample(5'b11000);
    expect_out("after_glitch", S_RT, 4'd3, 1'b0);
`endif

    run(5'b00011, E);
    expect_out("lt", S_LT, 4'd3, 1'b0);

    run(5'b00000, E);
    expect_out("srch_l", S_SRCH_L, 4'd15, 1'b1);
    run(5'b00000, LTO - 1);
    expect_out("srch_l_15", S_SRCH_L, 4'd15, 1'b1);
    sample(5'b00000);
    expect_out("timeout", S_STOP, 4'd0, 1'b1);
    sample(5'b00000);
    expect_out("timeout_hold", S_STOP, 4'd0, 1'b1);

    run(5'b00100, E);
    expect_out("reacq", S_STRI, 4'd0, 1'b0);

    run(5'b11111, E - 1 + SC - 1);
    chk("stop_confirming", 32'(state), 32'(S_STRI));
    sample(5'b11111);
    expect_out("stop", S_STOP, 4'd0, 1'b0);

    // Interrupted confirmation: 3 all-active, then one non-all decision.
    run(5'b00100, E);
    chk("leave_stop", 32'(state), 32'(S_STRI));
    run(5'b11111, E - 1 + 3);
    run(5'b00100, E);
    chk("restart_nonall", 32'(state), 32'(S_STRI));
    run(5'b11111, E - 1 + SC - 1);
    chk("restart_7", 32'(state), 32'(S_STRI));
    sample(5'b11111);
    chk("restart_8", 32'(state), 32'(S_STOP));

    // Into SRCH_R, then reset at lost_cnt = 10.
    run(5'b11000, E);
    chk("rt_again", 32'(state), 32'(S_RT));
    run(5'b00000, E);
    expect_out("srch_r", S_SRCH_R, 4'd15, 1'b1);
    run(5'b00000, 10);
    chk("srch_r_10", 32'(state), 32'(S_SRCH_R));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_out("mid_reset", S_STRI, 4'd0, 1'b0);
    sample(5'b00000);
    expect_out("post_rst_srch", S_SRCH_L, 4'd15, 1'b1);
    run(5'b00000, LTO - 1);
    chk("post_rst_15", 32'(state), 32'(S_SRCH_L));
    sample(5'b00000);
    expect_out("post_rst_timeout", S_STOP, 4'd0, 1'b1);

    run(5'b10000, E);
    expect_out("edge_left", S_RT, 4'd2, 1'b0);
    run(5'b01111, E);
    expect_out("right_heavy", S_LT, 4'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
